stream_mux_rr: RTL and testbench
================================

// Module: stream_mux_rr
// PURPOSE
//  Parametrised N-channel packet stream multiplexer; successor to the fixed 4:1 gate-level mux.
//  Merges N valid/ready input streams onto one registered output stream.
//  Channel is chosen per packet, by fixed select or by round-robin arbitration.
//  A channel holds the output until its last beat; sits ahead of shared downstream datapaths.
// PARAMETERS
//  N_CH   4  number of input channels (>=2)
//  WIDTH  8  data bits per beat
//  SEL_W  $clog2(N_CH)  localparam, channel index width
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  mode       in   1           0 = FIXED (use sel), 1 = RR (round-robin)
//  sel        in   SEL_W       channel in FIXED mode
//  in_valid   in   N_CH        per-channel beat valid
//  in_data    in   N_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//  in_last    in   N_CH        per-channel end-of-packet
//  in_ready   out  N_CH        per-channel accept; one-hot or zero
//  out_valid  out  1           output beat valid
//  out_data   out  WIDTH       output beat
//  out_last   out  1           output end-of-packet
//  out_ch     out  SEL_W       source channel of the current beat
//  out_ready  in   1           downstream accept
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_last=0, out_ch=0, in_ready=0, rr_ptr=0, state=IDLE.
//  Transfer: in on in_valid[g]&&in_ready[g]; out on out_valid&&out_ready.
//  Output register: load_en = !out_valid || out_ready. Latency: accepted beat appears 1 cycle later.
//  While out_valid&&!out_ready: out_data/last/ch hold stable; in_ready all 0.
//  FSM IDLE: pick grant g. FIXED: g=sel, only if in_valid[sel]. RR: first valid channel at
//   rr_ptr, rr_ptr+1, ..., wrapping N_CH-1 -> 0. No valid candidate: stay IDLE, in_ready=0.
//   With a candidate: in_ready[g]=load_en, same cycle, no idle bubble.
//   Beat accepted with in_last=0 -> LOCKED(g). With in_last=1 -> stays IDLE.
//  FSM LOCKED(g): in_ready[g]=load_en; other in_ready=0. mode/sel changes ignored until packet end.
//   Beat accepted with in_last=1 -> IDLE.
//  rr_ptr updates on acceptance of a last beat: rr_ptr <= (g==N_CH-1) ? 0 : g+1. Both modes.
//  Single-beat packets (in_last=1 on first beat) are legal and rotate arbitration.
//  sel >= N_CH in FIXED mode: no grant, in_ready=0.
//  Back-to-back: a last beat and the next packet's first beat may leave on consecutive cycles.
//  Async reset mid-packet: packet is dropped, all state returns to reset values.
//  No beat is duplicated or lost across reset deassertion.
// STRUCTURE
//  Package stream_mux_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1; state enum {IDLE, LOCKED}.
//  Sub-module rr_arbiter #(N): inputs req[N] and ptr; output one-hot gnt[N] and index.
//   Purely combinational rotate-priority logic.
//  Top: FSM, grant register, rr_ptr, output register, data select by indexed part-select.
// TESTING
//  1 Reset: rst_n low mid-traffic -> all outputs 0 async; first packet after reset granted to ch0 in RR.
//  2 FIXED, sel=2, ch2 sends 3-beat pkt A0,A1,A2; ch0 valid throughout.
//    -> out_data A0..A2, out_ch=2, in_ready[0]=0; sel switched to 1 mid-packet has no effect.
//  3 RR, all 4 channels valid with 2-beat pkts -> packets in order ch0,ch1,ch2,ch3,ch0; no gap cycles.
//  4 Backpressure: out_ready=0 for 3 cycles mid-packet -> out_data stable, in_ready=0.
//    Resume gives no loss or duplicate.
//  5 RR, only ch3 valid, single-beat pkts (last=1) -> out_ch=3 every cycle.
//    rr_ptr wraps to 0; ch1 then valid wins next.
//  6 FIXED, sel=3 with N_CH=3 build -> in_ready stays 0, out_valid stays 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin packet stream multiplexer.
//  MODE_FIXED / MODE_RR : values of the mode input
//  state_t              : arbitration FSM state (IDLE = choosing, LOCKED = mid-packet)
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/stream_mux_rr_if.sv
// Bundles the N input streams and the single output stream of stream_mux_rr.
//  in_valid/in_data/in_last : per-channel beats, channel i data at [i*WIDTH +: WIDTH]
//  in_ready                 : per-channel accept from the mux (one-hot or zero)
//  out_valid/out_data/out_last/out_ch : registered merged stream and its source channel
//  out_ready                : downstream accept
// Handshake: a beat moves when valid && ready are both high on a rising clock edge;
// once valid is raised the beat (data/last/ch) stays stable until it is accepted.
interface stream_mux_rr_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
) ();
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_last;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_ready;

  // Source/sink environment side.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch
  );

  // Multiplexer side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter.
//  req   : request vector
//  ptr   : highest-priority index; priority falls off ptr, ptr+1, ... wrapping to 0
//  gnt   : one-hot grant (all zero when nothing requests)
//  index : binary index of the granted request (0 when nothing requests)
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] index
);

  logic found;
  int   c;

  always_comb begin
    gnt   = '0;
    index = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        index  = IW'(c);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel packet stream multiplexer with fixed-select or round-robin arbitration.
//  clk, rst_n   : rising-edge clock, asynchronous active-low reset
//  mode, sel    : 0 = FIXED (channel sel), 1 = RR; sampled only between packets
//  bus          : input streams and registered output stream (stream_mux_rr_if.slave)
//  dbg_state_o  : arbitration FSM state
//  dbg_rr_ptr_o : round-robin priority pointer
// A granted channel owns the output until its last beat is accepted.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  stream_mux_rr_if.slave   bus,
  output state_t           dbg_state_o,
  output logic [SEL_W-1:0] dbg_rr_ptr_o
);

  state_t           state_q;
  logic [SEL_W-1:0] grant_q;
  logic [SEL_W-1:0] rr_ptr_q;
  logic             run_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic [SEL_W-1:0] out_ch_q;

  logic [N_CH-1:0]  arb_gnt;
  logic [SEL_W-1:0] arb_idx;
  logic             load_en;
  logic             sel_ok;
  logic             cand;
  logic             accept;
  logic             beat_last;
  logic [SEL_W-1:0] g;
  logic [WIDTH-1:0] beat_data;
  logic [N_CH-1:0]  in_ready_c;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req   (bus.in_valid),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .index (arb_idx)
  );

  // Output register can take a new beat when empty or draining this cycle.
  assign load_en = !out_valid_q || bus.out_ready;
  // sel may encode channels that do not exist when N_CH is not a power of two.
  assign sel_ok  = ({1'b0, sel} < (SEL_W+1)'(N_CH));

  always_comb begin
    g    = '0;
    cand = 1'b0;
    if (state_q == LOCKED) begin
      g    = grant_q;
      cand = 1'b1;
    end else if (mode == MODE_RR) begin
      g    = arb_idx;
      cand = |arb_gnt;
    end else if (sel_ok) begin
      g    = sel;
      cand = bus.in_valid[sel];
    end
    in_ready_c = '0;
    // run_q keeps in_ready low during reset and for the edge that releases it,
    // so nothing is accepted while the output register is being cleared.
    if (cand && run_q) in_ready_c[g] = load_en;
    accept    = |(in_ready_c & bus.in_valid);
    beat_last = bus.in_last[g];
    beat_data = bus.in_data[int'(g)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      run_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= beat_data;
        out_last_q  <= beat_last;
        out_ch_q    <= g;
        if (beat_last) begin
          state_q  <= IDLE;
          rr_ptr_q <= (g == SEL_W'(N_CH-1)) ? '0 : g + SEL_W'(1);
        end else begin
          state_q <= LOCKED;
          grant_q <= g;
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;
  assign dbg_state_o   = state_q;
  assign dbg_rr_ptr_o  = rr_ptr_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance fed by per-channel packet
// queues, plus a 3-channel instance used for the out-of-range select case.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       mode;
  logic [1:0] sel;
  logic       mode3;
  logic [1:0] sel3;
  state_t     dbg_state, dbg_state3;
  logic [1:0] dbg_ptr, dbg_ptr3;

  stream_mux_rr_if #(.N_CH(4), .WIDTH(8)) bus ();
  stream_mux_rr_if #(.N_CH(3), .WIDTH(8)) bus3 ();

  stream_mux_rr #(.N_CH(4), .WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .bus(bus.slave),
    .dbg_state_o(dbg_state), .dbg_rr_ptr_o(dbg_ptr)
  );

  stream_mux_rr #(.N_CH(3), .WIDTH(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .bus(bus3.slave),
    .dbg_state_o(dbg_state3), .dbg_rr_ptr_o(dbg_ptr3)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- sources and output capture ----------------
  // Source entries are {last, data}; captured beats are {ch, last, data}.
  logic [8:0]  q0[$], q1[$], q2[$], q3[$];
  logic [10:0] got_q[$];
  int          got_cyc[$];
  logic [10:0] exp_q[$];

  function automatic logic [10:0] beat(input int ch, input logic last, input logic [7:0] d);
    return {2'(ch), last, d};
  endfunction

  task automatic push(input int ch, input logic [7:0] d, input logic last);
    case (ch)
      0: q0.push_back({last, d});
      1: q1.push_back({last, d});
      2: q2.push_back({last, d});
      default: q3.push_back({last, d});
    endcase
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  // Driver/monitor: sample handshakes at negedge, advance sources just after posedge.
  initial begin
    logic [3:0]  acc;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.in_last  = '0;
    forever begin
      @(negedge clk);
      acc = bus.in_valid & bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back({bus.out_ch, bus.out_last, bus.out_data});
        got_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      if (acc[0] && q0.size() > 0) q0.delete(0);
      if (acc[1] && q1.size() > 0) q1.delete(0);
      if (acc[2] && q2.size() > 0) q2.delete(0);
      if (acc[3] && q3.size() > 0) q3.delete(0);
      v = '0; l = '0; d = '0;
      if (q0.size() > 0) begin v[0] = 1'b1; l[0] = q0[0][8]; d[7:0]   = q0[0][7:0]; end
      if (q1.size() > 0) begin v[1] = 1'b1; l[1] = q1[0][8]; d[15:8]  = q1[0][7:0]; end
      if (q2.size() > 0) begin v[2] = 1'b1; l[2] = q2[0][8]; d[23:16] = q2[0][7:0]; end
      if (q3.size() > 0) begin v[3] = 1'b1; l[3] = q3[0][8]; d[31:24] = q3[0][7:0]; end
      bus.in_valid = v;
      bus.in_last  = l;
      bus.in_data  = d;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_got(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    mode = MODE_RR; sel = 2'd0; bus.out_ready = 1'b1;
    do_reset();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_last !== 1'b0 ||
        bus.out_ch !== 2'd0 || dbg_state !== IDLE || dbg_ptr !== 2'd0) begin
      n_err++;
      $display("FAIL reset_idle: valid=%b data=%h last=%b ch=%0d st=%0d ptr=%0d, need all 0",
               bus.out_valid, bus.out_data, bus.out_last, bus.out_ch, dbg_state, dbg_ptr);
    end
    for (int i = 0; i < 4; i++) push(1, 8'h10 + 8'(i), i == 3);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_last !== 1'b0 ||
        bus.out_ch !== 2'd0 || bus.in_ready !== 4'b0000 || dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_async: valid=%b data=%h last=%b ch=%0d rdy=%b st=%0d, need all 0",
               bus.out_valid, bus.out_data, bus.out_last, bus.out_ch, bus.in_ready, dbg_state);
    end
    clear_all();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    push(2, 8'h2A, 1'b1);
    push(0, 8'h0A, 1'b1);
    exp_q.push_back(beat(0, 1'b1, 8'h0A));
    exp_q.push_back(beat(2, 1'b1, 8'h2A));
    wait_got(2, 20);
    repeat (3) tick();
    n_vec++;
    if (got_q.size() != 2) begin
      n_err++;
      $display("FAIL reset_count: got %0d beats, need 2", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL reset_after beat %0d: got %h need %h", i,
                 (i < got_q.size()) ? got_q[i] : 11'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_fixed();
    int k;
    logic saw_rdy0;
    mode = MODE_FIXED; sel = 2'd2; bus.out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) push(0, 8'h00 + 8'(i), i == 4);
    push(2, 8'hA0, 1'b0); push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b1);
    push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b1);
    exp_q.push_back(beat(2, 1'b0, 8'hA0));
    exp_q.push_back(beat(2, 1'b0, 8'hA1));
    exp_q.push_back(beat(2, 1'b1, 8'hA2));
    exp_q.push_back(beat(1, 1'b0, 8'h10));
    exp_q.push_back(beat(1, 1'b1, 8'h11));
    saw_rdy0 = 1'b0;
    k = 0;
    while (dbg_state != LOCKED && k < 10) begin
      tick();
      saw_rdy0 |= bus.in_ready[0];
      k++;
    end
    n_vec++;
    if (dbg_state !== LOCKED) begin
      n_err++;
      $display("FAIL fixed_lock: state %0d, need LOCKED", dbg_state);
    end
    sel = 2'd1;
    #1;
    n_vec++;
    if (bus.in_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL fixed_sel_change: in_ready %b, need 0100", bus.in_ready);
    end
    k = 0;
    while (got_q.size() < 5 && k < 30) begin
      tick();
      saw_rdy0 |= bus.in_ready[0];
      k++;
    end
    n_vec++;
    if (saw_rdy0 !== 1'b0) begin
      n_err++;
      $display("FAIL fixed_rdy0: in_ready[0] seen %b, need 0", saw_rdy0);
    end
    sel = 2'd0;
    for (int i = 0; i < 5; i++) exp_q.push_back(beat(0, i == 4, 8'(i)));
    wait_got(10, 30);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL fixed beat %0d: got %h need %h", i,
                 (i < got_q.size()) ? got_q[i] : 11'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    mode = MODE_RR; sel = 2'd0; bus.out_ready = 1'b1;
    do_reset();
    push(0, 8'h00, 1'b0); push(0, 8'h01, 1'b1); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
    push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b1);
    push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1);
    push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b1);
    exp_q.push_back(beat(0, 1'b0, 8'h00)); exp_q.push_back(beat(0, 1'b1, 8'h01));
    exp_q.push_back(beat(1, 1'b0, 8'h10)); exp_q.push_back(beat(1, 1'b1, 8'h11));
    exp_q.push_back(beat(2, 1'b0, 8'h20)); exp_q.push_back(beat(2, 1'b1, 8'h21));
    exp_q.push_back(beat(3, 1'b0, 8'h30)); exp_q.push_back(beat(3, 1'b1, 8'h31));
    exp_q.push_back(beat(0, 1'b0, 8'h02)); exp_q.push_back(beat(0, 1'b1, 8'h03));
    wait_got(10, 40);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rr_order beat %0d: got %h need %h", i,
                 (i < got_q.size()) ? got_q[i] : 11'h0, exp_q[i]);
      end
    end
    n_vec++;
    if (got_q.size() < 10 || got_cyc[9] - got_cyc[0] != 9) begin
      n_err++;
      $display("FAIL rr_gapless: %0d beats span %0d cycles, need 10 beats in 9",
               got_q.size(), (got_q.size() >= 10) ? got_cyc[9] - got_cyc[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    mode = MODE_RR; sel = 2'd0; bus.out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) push(1, 8'h50 + 8'(i), i == 5);
    wait_got(2, 20);
    held = 8'h50 + 8'(got_q.size());
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.out_ch !== 2'd1 ||
          bus.in_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL stall cyc %0d: valid=%b data=%h ch=%0d rdy=%b, need 1 %h 1 0000",
                 c, bus.out_valid, bus.out_data, bus.out_ch, bus.in_ready, held);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(beat(1, i == 5, 8'h50 + 8'(i)));
    wait_got(6, 30);
    repeat (3) tick();
    n_vec++;
    if (got_q.size() != 6) begin
      n_err++;
      $display("FAIL stall_count: got %0d beats, need 6", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL stall beat %0d: got %h need %h", i,
                 (i < got_q.size()) ? got_q[i] : 11'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_single_beat();
    mode = MODE_RR; sel = 2'd0; bus.out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(3, 8'h30 + 8'(i), 1'b1);
      exp_q.push_back(beat(3, 1'b1, 8'h30 + 8'(i)));
    end
    wait_got(4, 20);
    n_vec++;
    if (dbg_ptr !== 2'd0) begin
      n_err++;
      $display("FAIL single_ptr_wrap: rr_ptr %0d, need 0", dbg_ptr);
    end
    n_vec++;
    if (got_q.size() < 4 || got_cyc[3] - got_cyc[0] != 3) begin
      n_err++;
      $display("FAIL single_gapless: %0d beats, need 4 on consecutive cycles", got_q.size());
    end
    push(3, 8'h3A, 1'b1);
    push(1, 8'h1A, 1'b1);
    exp_q.push_back(beat(1, 1'b1, 8'h1A));
    exp_q.push_back(beat(3, 1'b1, 8'h3A));
    wait_got(6, 20);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL single beat %0d: got %h need %h", i,
                 (i < got_q.size()) ? got_q[i] : 11'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_bad_sel();
    mode3 = MODE_FIXED; sel3 = 2'd3;
    bus3.out_ready = 1'b1;
    bus3.in_data   = {8'h2C, 8'h1C, 8'h0C};
    bus3.in_last   = 3'b111;
    bus3.in_valid  = 3'b111;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (bus3.in_ready !== 3'b000 || bus3.out_valid !== 1'b0 ||
          dbg_state3 !== IDLE || dbg_ptr3 !== 2'd0) begin
        n_err++;
        $display("FAIL bad_sel cyc %0d: rdy=%b valid=%b st=%0d ptr=%0d, need 000 0 IDLE 0",
                 c, bus3.in_ready, bus3.out_valid, dbg_state3, dbg_ptr3);
      end
    end
    sel3 = 2'd2;
    tick();
    n_vec++;
    if (bus3.out_valid !== 1'b1 || bus3.out_data !== 8'h2C || bus3.out_ch !== 2'd2) begin
      n_err++;
      $display("FAIL good_sel3: valid=%b data=%h ch=%0d, need 1 2c 2",
               bus3.out_valid, bus3.out_data, bus3.out_ch);
    end
    bus3.in_valid = 3'b000;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    mode  = MODE_RR; sel  = 2'd0;
    mode3 = MODE_FIXED; sel3 = 2'd0;
    bus.out_ready  = 1'b1;
    bus3.in_valid  = '0;
    bus3.in_data   = '0;
    bus3.in_last   = '0;
    bus3.out_ready = 1'b1;
    tick();
    test_reset();
    test_fixed();
    test_back_to_back();
    test_backpressure();
    test_single_beat();
    test_bad_sel();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
